// File: rtl/sr_cmd_arbiter.sv
// sr_cmd_arbiter: round-robin serializer of set/reset/toggle commands onto a
// bank of SR flip-flops, issuing at most one one-hot s/r pulse per command.
module sr_cmd_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int AW    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*2-1:0]    req_op,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NBITS-1:0]     q_in,
  output logic [NBITS-1:0]     sr_s,
  output logic [NBITS-1:0]     sr_r,
  output logic                 err_addr,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_RESET  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] req_ready_q, req_ready_d;
  logic [NBITS-1:0] sr_s_q, sr_s_d;
  logic [NBITS-1:0] sr_r_q, sr_r_d;
  logic            err_addr_q, err_addr_d;
  logic            busy_q, busy_d;

  logic            any_valid;
  logic            arb_slot;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   cand_idx;
  logic [AW-1:0]   sel_addr;
  logic [1:0]      sel_op;
  logic            addr_ok;
  logic            q_cur;

  // Scan downward so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    grant_idx = '0;
    cand_idx  = '0;
    any_valid = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand_idx = PW'((int'(rr_ptr_q) + i) % NREQ);
      if (req_valid[cand_idx]) begin
        grant_idx = cand_idx;
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    sel_addr = req_addr[grant_idx*AW +: AW];
    sel_op   = req_op[grant_idx*2 +: 2];
    addr_ok  = (int'(sel_addr) < NBITS);
    q_cur    = addr_ok ? q_in[sel_addr] : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      req_ready_q <= '0;
      sr_s_q      <= '0;
      sr_r_q      <= '0;
      err_addr_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      req_ready_q <= req_ready_d;
      sr_s_q      <= sr_s_d;
      sr_r_q      <= sr_r_d;
      err_addr_q  <= err_addr_d;
      busy_q      <= busy_d;
    end
  end

  // ISSUE is always followed by SETTLE, so requests arriving during ISSUE wait.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    arb_slot = 1'b0;
    case (state_q)
      IDLE, SETTLE: begin
        if (any_valid) begin
          state_d  = ISSUE;
          arb_slot = 1'b1;
          rr_ptr_d = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE:   state_d = SETTLE;
      default: state_d = IDLE;
    endcase
  end

  // Issue-cycle outputs are computed at the grant edge, toggles use q sampled then.
  always_comb begin
    req_ready_d = '0;
    sr_s_d      = '0;
    sr_r_d      = '0;
    err_addr_d  = 1'b0;
    busy_d      = (state_d != IDLE);
    if (arb_slot) begin
      req_ready_d[grant_idx] = 1'b1;
      if (!addr_ok) begin
        err_addr_d = 1'b1;
      end else begin
        case (op_e'(sel_op))
          OP_SET:    sr_s_d[sel_addr] = 1'b1;
          OP_RESET:  sr_r_d[sel_addr] = 1'b1;
          OP_TOGGLE: begin
            if (q_cur) sr_r_d[sel_addr] = 1'b1;
            else       sr_s_d[sel_addr] = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign req_ready = req_ready_q;
  assign sr_s      = sr_s_q;
  assign sr_r      = sr_r_q;
  assign err_addr  = err_addr_q;
  assign busy      = busy_q;

endmodule

// File: doc/sr_cmd_arbiter.md
Name: sr_cmd_arbiter

Overview:
Round-robin arbiter that lets NREQ requesters share a bank of NBITS srflipflop instances. Each requester issues a set, reset, toggle or no-op command against one bit. The block serializes these commands into single-cycle, one-hot s/r pulses on the bank's inputs. By construction it never drives s=r=1 on any bit, and it gives each command time to settle before the next toggle reads q.

Parameters:
NREQ, 4, number of requesters
NBITS, 8, number of SR flip-flops in the bank
AW, 3, address width (must satisfy 2**AW >= NBITS)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NREQ  per-requester command valid; held until matching req_ready
req_addr  input  NREQ*AW  per-requester bit index; requester i uses slice [i*AW +: AW]
req_op  input  NREQ*2  per-requester op; requester i uses slice [i*2 +: 2]; 00 nop, 01 reset, 10 set, 11 toggle
req_ready  output  NREQ  one-hot, single-cycle grant/acknowledge
q_in  input  NBITS  current q of the flip-flop bank
sr_s  output  NBITS  set pulses to the bank, at most one bit high
sr_r  output  NBITS  reset pulses to the bank, at most one bit high
err_addr  output  1  one-cycle pulse: the granted command had addr >= NBITS
busy  output  1  high whenever the state is not IDLE

Behaviour:
- Clock and reset: one clock domain. rst is asynchronous and active-high.
  - While rst is high: state=IDLE, rr_ptr=0, and req_ready, sr_s, sr_r, err_addr and busy are all 0.
  - All outputs are registered.
- States: IDLE, ISSUE, SETTLE.
- Arbitration in IDLE or SETTLE: at each rising edge, if any req_valid is high, grant the first valid requester found by searching upward from rr_ptr, wrapping modulo NREQ.
  - Capture that requester's addr and op at the same edge.
  - Update rr_ptr to (g+1) mod NREQ.
  - Next state is ISSUE.
- No request: if no req_valid is high at the edge, IDLE stays IDLE and SETTLE goes to IDLE.
- ISSUE (exactly 1 cycle):
  - req_ready[g]=1; all other req_ready bits are 0.
  - op=10: sr_s[addr]=1.
  - op=01: sr_r[addr]=1.
  - op=11: if q_in[addr] sampled at the grant edge was 1, sr_r[addr]=1; otherwise sr_s[addr]=1.
  - op=00: sr_s=sr_r=0; the grant still occurs.
  - addr >= NBITS: sr_s=sr_r=0 and err_addr=1; the grant still occurs.
  - Next state is always SETTLE.
- SETTLE (1 cycle): sr_s, sr_r, req_ready and err_addr are all 0.
  - The bank captures the ISSUE pulse at the ISSUE->SETTLE edge, so q_in is valid when SETTLE arbitrates.
- Throughput and latency:
  - Steady-state throughput is one command per 2 cycles.
  - Latency from req_valid sampled (edge k) to pulse is 1 cycle: the pulse is high between edge k and edge k+1.
  - q reflects the command after edge k+1.
- Requester handshake: the requester must keep valid, addr and op stable until it sees req_ready. It may drop valid or present a new command in the cycle after req_ready. A request that is still valid in the SETTLE cycle after its own grant is treated as a new command.
- Invariant: sr_s & sr_r == 0, and popcount(sr_s | sr_r) <= 1, in every cycle.
- Reset mid-operation: asserting rst during ISSUE drops the pulse and grant immediately (asynchronously). The command is lost; the requester must re-issue it.
- Masking: changes on req_valid while the state is ISSUE are ignored until the next edge at which the state is SETTLE.

Test Plan:
- Reset: rst=1 for 2 cycles with all 4 req_valid high -> req_ready=0, sr_s=sr_r=0, busy=0. After release, the first grant goes to requester 0.
- Single set: req_valid=4'b0001, addr0=3, op0=10 -> next cycle sr_s=8'h08, sr_r=0, req_ready=4'b0001 for exactly 1 cycle. q_in[3]=1 afterwards.
- Contention: req_valid=4'b1111 held continuously, each requester set to a distinct bit -> grants in order 0,1,2,3,0 spaced 2 cycles apart. No two ready pulses are adjacent, and sr_s&sr_r=0 throughout.
- Toggle: q[5]=1, requester 2 issues op=11 addr=5 -> sr_r=8'h20. An immediate repeat from requester 2 -> sr_s=8'h20, and q[5] returns to 1.
- Bad address, run with NBITS=6: requester 1 issues addr=7 op=10 -> err_addr=1 for 1 cycle, sr_s=sr_r=0, req_ready=4'b0010.
- Reset during ISSUE: assert rst mid-cycle while sr_s=8'h01 -> sr_s drops to 0 without waiting for a clock edge. After release, rr_ptr=0 and the state is IDLE.
